// File: rtl/branch_flush_pkg.sv
// Shared types and constants for the branch-redirect / pipeline-flush controller.
package branch_flush_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        ISSUE = 2'd2
    } state_e;

endpackage

// File: rtl/branch_flush_ctrl_if.sv
// Redirect request / flush / PC-redirect bundle between the execute-stage
// redirect sources, the fetch/decode registers and the PC mux.
// Optional feature macro: BRANCH_FLUSH_STATS_EN (adds statistics counters).
interface branch_flush_ctrl_if
    import branch_flush_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int NUM_SRC = 2
);

    logic                    stall;
    logic [NUM_SRC-1:0]      redirect_valid;
    logic [NUM_SRC*XLEN-1:0] redirect_target;
    logic                    flush;
    logic                    pc_sel;
    logic [XLEN-1:0]         pc_redirect;
    logic                    pc_redirect_valid;
    logic                    busy;

`ifdef BRANCH_FLUSH_STATS_EN
    logic [31:0]             redirect_cnt;
    logic [31:0]             flush_cycle_cnt;

    modport master (
        output stall, redirect_valid, redirect_target,
        input  flush, pc_sel, pc_redirect, pc_redirect_valid, busy,
        input  redirect_cnt, flush_cycle_cnt
    );

    modport slave (
        input  stall, redirect_valid, redirect_target,
        output flush, pc_sel, pc_redirect, pc_redirect_valid, busy,
        output redirect_cnt, flush_cycle_cnt
    );
`else
    modport master (
        output stall, redirect_valid, redirect_target,
        input  flush, pc_sel, pc_redirect, pc_redirect_valid, busy
    );

    modport slave (
        input  stall, redirect_valid, redirect_target,
        output flush, pc_sel, pc_redirect, pc_redirect_valid, busy
    );
`endif

endinterface

// File: rtl/branch_flush_ctrl_redirect_arbiter.sv
// Combinational fixed-priority redirect arbiter: source 0 has the highest
// priority. Also intended for the exception/trap redirect path.
module redirect_arbiter
    import branch_flush_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0]      valid,
    input  logic [NUM_SRC*XLEN-1:0] target,
    output logic                    any_valid,
    output logic [XLEN-1:0]         win_target
);

    // Scan from the lowest priority upwards so the lowest set index is the last write.
    always_comb begin
        any_valid  = |valid;
        win_target = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (valid[i]) begin
                win_target = target[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/branch_flush_ctrl.sv
// Branch-redirect and pipeline-flush controller. Accepts the highest-priority
// redirect, flushes fetch/decode for FLUSH_DEPTH cycles (counting the request
// cycle), then strobes the held target into the PC for one cycle. Stall
// freezes everything; a new redirect while busy restarts the sequence.
// Optional feature macro: BRANCH_FLUSH_STATS_EN (redirect / flush-cycle counters).
module branch_flush_ctrl
    import branch_flush_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int FLUSH_DEPTH = 2,
    parameter int NUM_SRC     = 2
) (
    input  logic         clk,
    input  logic         rst,
    branch_flush_ctrl_if.slave bus
);

    localparam int               CNT_W    = $clog2(FLUSH_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state;
    state_e            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_dec;
    logic [XLEN-1:0]   target_q;
    logic              arb_any;
    logic [XLEN-1:0]   arb_target;
    logic              accept;

    redirect_arbiter #(
        .XLEN    (XLEN),
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .valid      (bus.redirect_valid),
        .target     (bus.redirect_target),
        .any_valid  (arb_any),
        .win_target (arb_target)
    );

    // Requests are only taken in unstalled cycles and never while reset is held.
    assign accept  = !rst && !bus.stall && arb_any;
    assign cnt_dec = cnt - CNT_ONE;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: acceptance always (re)starts the sequence; ISSUE follows once cnt reaches 1.
    always_comb begin
        state_next = state;
        if (!bus.stall) begin
            if (accept) begin
                state_next = (CNT_LOAD == CNT_ONE) ? ISSUE : FLUSH;
            end else begin
                case (state)
                    IDLE:    state_next = IDLE;
                    FLUSH:   if (cnt_dec == CNT_ONE) state_next = ISSUE;
                    ISSUE:   state_next = IDLE;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Flush counter and held target; the counter never decrements below 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            target_q <= '0;
        end else if (accept) begin
            cnt      <= CNT_LOAD;
            target_q <= arb_target;
        end else if (!bus.stall && state == FLUSH && cnt > CNT_ONE) begin
            cnt      <= cnt_dec;
        end
    end

    // Outputs: the strobe is withheld when stalled or when a restart lands on ISSUE.
    always_comb begin
        bus.flush             = accept || state == FLUSH || state == ISSUE;
        bus.pc_sel            = bus.flush;
        bus.pc_redirect       = target_q;
        bus.pc_redirect_valid = state == ISSUE && !bus.stall && !accept;
        bus.busy              = state != IDLE;
    end

`ifdef BRANCH_FLUSH_STATS_EN
    logic [31:0] redirect_q;
    logic [31:0] flush_cycle_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating counters of accepted redirects and flushed cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_q    <= '0;
            flush_cycle_q <= '0;
        end else begin
            if (accept)    redirect_q    <= sat_inc(redirect_q);
            if (bus.flush) flush_cycle_q <= sat_inc(flush_cycle_q);
        end
    end

    assign bus.redirect_cnt    = redirect_q;
    assign bus.flush_cycle_cnt = flush_cycle_q;
`endif

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Self-checking bench for branch_flush_ctrl (FLUSH_DEPTH = 2, two sources).
// Expected PC-redirect strobes are queued with their cycle and target when the
// request is driven, and popped when the DUT strobes.
module tb_branch_flush_ctrl;
    import branch_flush_pkg::*;

    localparam int XLEN    = 32;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_flush_ctrl_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) bif ();

    branch_flush_ctrl #(
        .XLEN        (XLEN),
        .FLUSH_DEPTH (DEPTH),
        .NUM_SRC     (NUM_SRC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic drive(input logic [1:0] v, input logic [31:0] t0, input logic [31:0] t1,
                         input logic st);
        bif.redirect_valid  = v;
        bif.redirect_target = {t1, t0};
        bif.stall           = st;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Sample at the falling edge and retire scoreboard entries.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL sb_missed: no strobe seen for target %h, required at cycle %0d (now %0d)",
                     e.tgt, e.at, cyc);
        end
        if (bif.pc_redirect_valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: strobe of %h at cycle %0d, required none",
                         bif.pc_redirect, cyc);
            end else begin
                e = sb.pop_front();
                if (e.at !== cyc || bif.pc_redirect !== e.tgt) begin
                    fails++;
                    $display("FAIL sb_strobe: got %h at cycle %0d, required %h at cycle %0d",
                             bif.pc_redirect, cyc, e.tgt, e.at);
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'b01, 32'h0000_0100, 32'h0, 1'b0);
        advance();
        advance();
        sample();
        tests++;
        if (bif.flush !== 1'b0 || bif.pc_sel !== 1'b0) begin
            fails++;
            $display("FAIL reset_flush: flush=%b pc_sel=%b, required 0 0", bif.flush, bif.pc_sel);
        end
        tests++;
        if (bif.busy !== 1'b0 || bif.pc_redirect_valid !== 1'b0 || bif.pc_redirect !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: busy=%b prv=%b pc_redirect=%h, required 0 0 0",
                     bif.busy, bif.pc_redirect_valid, bif.pc_redirect);
        end
        #2 rst = 1'b0;
        advance();
        // Accept 0x100, then reset asynchronously while in FLUSH.
        drive(2'b01, 32'h0000_0100, 32'h0, 1'b0);
        sample();
        tests++;
        if (bif.flush !== 1'b1) begin
            fails++;
            $display("FAIL reset_accept_flush: flush=%b, required 1", bif.flush);
        end
        advance();
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        sample();
        tests++;
        if (bif.busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre_busy: busy=%b, required 1", bif.busy);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({bif.flush, bif.pc_sel, bif.busy, bif.pc_redirect_valid} !== 4'b0000 ||
            bif.pc_redirect !== 32'h0) begin
            fails++;
            $display("FAIL reset_async: flush/pc_sel/busy/prv=%b pc_redirect=%h, required 0000 0",
                     {bif.flush, bif.pc_sel, bif.busy, bif.pc_redirect_valid}, bif.pc_redirect);
        end
        #1 rst = 1'b0;
        idle_cycles(5);
        tests++;
        if (bif.pc_redirect !== 32'h0) begin
            fails++;
            $display("FAIL reset_target: pc_redirect=%h, required 0", bif.pc_redirect);
        end
    endtask

    task automatic test_single();
        logic exp_flush[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic exp_busy[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int t;
        t = cyc;
        drive(2'b01, 32'h0000_0040, 32'h0, 1'b0);
        sb.push_back('{t + DEPTH, 32'h0000_0040});
        for (int i = 0; i < 5; i++) begin
            sample();
            tests++;
            if (bif.flush !== exp_flush[i] || bif.pc_sel !== exp_flush[i]) begin
                fails++;
                $display("FAIL single_flush[%0d]: flush=%b pc_sel=%b, required %b",
                         i, bif.flush, bif.pc_sel, exp_flush[i]);
            end
            tests++;
            if (bif.busy !== exp_busy[i]) begin
                fails++;
                $display("FAIL single_busy[%0d]: busy=%b, required %b", i, bif.busy, exp_busy[i]);
            end
            advance();
            drive(2'b00, 32'h0, 32'h0, 1'b0);
        end
    endtask

    task automatic test_priority();
        int t;
        t = cyc;
        drive(2'b11, 32'h0000_0080, 32'h0000_00C0, 1'b0);
        sb.push_back('{t + DEPTH, 32'h0000_0080});
        sample();
        advance();
        idle_cycles(6);
        tests++;
        if (bif.pc_redirect !== 32'h0000_0080) begin
            fails++;
            $display("FAIL priority_target: pc_redirect=%h, required 00000080", bif.pc_redirect);
        end
    endtask

    task automatic test_stall();
        int t;
        t = cyc;
        drive(2'b01, 32'h0000_0500, 32'h0, 1'b0);
        sb.push_back('{t + 5, 32'h0000_0500});
        sample();
        advance();
        for (int i = 1; i <= 3; i++) begin
            // A request during stall must be ignored.
            drive(2'b11, 32'h0000_0999, 32'h0000_0999, 1'b1);
            sample();
            tests++;
            if (bif.flush !== 1'b1 || bif.busy !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold[%0d]: flush=%b busy=%b, required 1 1",
                         i, bif.flush, bif.busy);
            end
            advance();
        end
        idle_cycles(4);
        tests++;
        if (bif.pc_redirect !== 32'h0000_0500) begin
            fails++;
            $display("FAIL stall_target: pc_redirect=%h, required 00000500", bif.pc_redirect);
        end
    endtask

    task automatic test_restart();
        int t;
        t = cyc;
        drive(2'b01, 32'h0000_0200, 32'h0, 1'b0);
        sample();
        advance();
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        sample();
        advance();
        drive(2'b01, 32'h0000_0300, 32'h0, 1'b0);
        sb.push_back('{t + 2 + DEPTH, 32'h0000_0300});
        sample();
        tests++;
        if (bif.pc_redirect_valid !== 1'b0 || bif.flush !== 1'b1 || bif.busy !== 1'b1) begin
            fails++;
            $display("FAIL restart_issue: prv=%b flush=%b busy=%b, required 0 1 1",
                     bif.pc_redirect_valid, bif.flush, bif.busy);
        end
        advance();
        idle_cycles(5);
    endtask

    task automatic test_back_to_back();
        int t;
        t = cyc;
        drive(2'b01, 32'h0000_0600, 32'h0, 1'b0);
        sample();
        advance();
        drive(2'b10, 32'h0, 32'h0000_0700, 1'b0);
        sb.push_back('{t + 1 + DEPTH, 32'h0000_0700});
        sample();
        advance();
        idle_cycles(5);
        tests++;
        if (bif.pc_redirect !== 32'h0000_0700) begin
            fails++;
            $display("FAIL b2b_target: pc_redirect=%h, required 00000700", bif.pc_redirect);
        end
    endtask

`ifdef BRANCH_FLUSH_STATS_EN
    task automatic test_stats();
        logic [31:0] r0;
        logic [31:0] f0;
        int          t;
        r0 = bif.redirect_cnt;
        f0 = bif.flush_cycle_cnt;
        for (int k = 0; k < 3; k++) begin
            t = cyc;
            drive(2'b01, 32'h0000_1000 + 32'(k), 32'h0, 1'b0);
            sb.push_back('{t + DEPTH, 32'h0000_1000 + 32'(k)});
            sample();
            advance();
            idle_cycles(5);
        end
        tests++;
        if (bif.redirect_cnt - r0 !== 32'd3) begin
            fails++;
            $display("FAIL stats_redirect: delta=%0d, required 3", bif.redirect_cnt - r0);
        end
        tests++;
        if (bif.flush_cycle_cnt - f0 !== 32'(3 * (DEPTH + 1))) begin
            fails++;
            $display("FAIL stats_flush_cycles: delta=%0d, required %0d",
                     bif.flush_cycle_cnt - f0, 3 * (DEPTH + 1));
        end
    endtask
`endif

    initial begin
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        test_reset();
        test_single();
        test_priority();
        test_stall();
        test_restart();
        test_back_to_back();
`ifdef BRANCH_FLUSH_STATS_EN
        test_stats();
`endif
        idle_cycles(3);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d strobes outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
